// File: rtl/jfpjc_pkg.sv
// Shared definitions for the JPEG compressor front end.
//
// Holds the MCU geometry constants and the strip scheduler state type so the
// scheduler and its address counter agree on block size and encoding.
package jfpjc_pkg;

  // One MCU is an 8x8 pixel block stored as 64 consecutive words in an EBR.
  localparam int MCU_WORDS = 64;
  localparam int MCU_DIM   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mcu_addr_counter.sv
// MCU address ripple counter.
//
// Walks the MCUs of one strip in order. MCUs are striped round-robin across
// the EBRs, so the EBR (block) index is the fast digit and the slot inside
// the EBR is the slow digit.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   clear   in   return to MCU 0 (end of strip)
//   step    in   advance to the next MCU
//   block   out  EBR index of the current MCU
//   slot    out  slot index of the current MCU inside its EBR
//   last    out  current MCU is the final one of the strip
module mcu_addr_counter #(
  parameter int num_ebr   = 5,
  parameter int num_slots = 8,
  parameter int block_w   = 3,
  parameter int slot_w    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  output logic [block_w-1:0] block,
  output logic [slot_w-1:0]  slot,
  output logic               last
);

  localparam logic [block_w-1:0] BLOCK_MAX = block_w'(num_ebr - 1);
  localparam logic [slot_w-1:0]  SLOT_MAX  = slot_w'(num_slots - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      block <= '0;
      slot  <= '0;
    end else if (step) begin
      // Block wraps after the last EBR and carries into the slot digit.
      if (block == BLOCK_MAX) begin
        block <= '0;
        slot  <= slot + slot_w'(1);
      end else begin
        block <= block + block_w'(1);
      end
    end
  end

  assign last = (block == BLOCK_MAX) && (slot == SLOT_MAX);

endmodule

// File: rtl/mcu_strip_scheduler.sv
// MCU strip scheduler.
//
// Watches the ingester's front-buffer select; every flip means an 8-row strip
// has been completed in the other buffer. The scheduler then hands the
// compressor the strip's MCUs one at a time (start pulse with buffer, EBR and
// base address) and waits for each done pulse. A strip that completes while
// the previous one is still being read is flagged as an overrun and queued.
//
// Optional feature macro: OVERRUN_COUNT_EN enables the saturating overrun
// event counter; without it overrun_count is constant zero.
//
// Ports:
//   clock               in   system clock
//   reset               in   synchronous active-high reset
//   frontbuffer_select  in   buffer the ingester is writing; a flip ends a strip
//   mcu_done            in   compressor finished the current MCU (1-cycle pulse)
//   overrun_clear       in   clears the sticky overrun flag (and counter)
//   mcu_start           out  1-cycle pulse: MCU address outputs are valid
//   mcu_buffer          out  buffer holding the strip being read
//   mcu_block_select    out  EBR holding the current MCU
//   mcu_base_addr       out  word address of the MCU's first pixel
//   mcu_first_of_frame  out  with mcu_start: first MCU of the frame
//   mcu_last_of_frame   out  with mcu_start: last MCU of the frame
//   busy                out  a strip is being issued
//   overrun             out  sticky overrun flag
//   overrun_count       out  saturating overrun event count
module mcu_strip_scheduler
  import jfpjc_pkg::*;
#(
  parameter int width_pix  = 320,
  parameter int height_pix = 240,
  parameter int num_ebr    = 5,
  parameter int ebr_size   = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frontbuffer_select,
  input  logic                        mcu_done,
  input  logic                        overrun_clear,
  output logic                        mcu_start,
  output logic                        mcu_buffer,
  output logic [$clog2(num_ebr)-1:0]  mcu_block_select,
  output logic [$clog2(ebr_size)-1:0] mcu_base_addr,
  output logic                        mcu_first_of_frame,
  output logic                        mcu_last_of_frame,
  output logic                        busy,
  output logic                        overrun,
  output logic [7:0]                  overrun_count
);

  localparam int MCUS       = width_pix / MCU_DIM;
  localparam int SLOTS      = MCUS / num_ebr;
  localparam int STRIPS     = height_pix / MCU_DIM;
  localparam int BLOCK_W    = $clog2(num_ebr);
  localparam int ADDR_W     = $clog2(ebr_size);
  localparam int WORD_SHIFT = $clog2(MCU_WORDS);
  localparam int SLOT_W     = ADDR_W - WORD_SHIFT;
  localparam int STRIP_W    = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam logic [STRIP_W-1:0] STRIP_MAX = STRIP_W'(STRIPS - 1);

  sched_state_t        state;
  sched_state_t        state_next;
  logic                fb_prev;
  logic                pending;
  logic                pend_buf;
  logic                buf_q;
  logic                overrun_q;
  logic [STRIP_W-1:0]  strip_idx;
  logic [SLOT_W-1:0]   slot;
  logic                mcu_last;
  logic                toggle;
  logic                take;
  logic                cnt_step;
  logic                strip_done;
  logic                overrun_event;

  // A strip just completed in the buffer the ingester was previously writing.
  assign toggle = (frontbuffer_select != fb_prev);

  // A flip finishing on the very cycle the last MCU is acknowledged is not an
  // overrun; a flip while another strip is already queued always is.
  assign overrun_event = toggle && (pending || ((state != IDLE) && !strip_done));

  mcu_addr_counter #(
    .num_ebr   (num_ebr),
    .num_slots (SLOTS),
    .block_w   (BLOCK_W),
    .slot_w    (SLOT_W)
  ) u_addr (
    .clock (clock),
    .reset (reset),
    .clear (strip_done),
    .step  (cnt_step),
    .block (mcu_block_select),
    .slot  (slot),
    .last  (mcu_last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the one-cycle control strobes. Done pulses are only
  // honoured in WAIT, so a stray done during ISSUE is dropped.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    cnt_step   = 1'b0;
    strip_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending || toggle) begin
          state_next = ISSUE;
          take       = 1'b1;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (mcu_done) begin
          if (mcu_last) begin
            state_next = IDLE;
            strip_done = 1'b1;
          end else begin
            state_next = ISSUE;
            cnt_step   = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strip bookkeeping: edge detect, pending strip queue, buffer latch, strip
  // position within the frame and the sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_prev   <= 1'b0;
      pending   <= 1'b0;
      pend_buf  <= 1'b0;
      buf_q     <= 1'b0;
      strip_idx <= '0;
      overrun_q <= 1'b0;
    end else begin
      fb_prev <= frontbuffer_select;

      // A flip seen while leaving IDLE wins over an older queued strip.
      if (take) begin
        pending <= 1'b0;
        buf_q   <= toggle ? fb_prev : pend_buf;
      end else if (toggle) begin
        pending  <= 1'b1;
        pend_buf <= fb_prev;
      end

      if (strip_done) begin
        strip_idx <= (strip_idx == STRIP_MAX) ? '0 : strip_idx + STRIP_W'(1);
      end

      if (overrun_event) begin
        overrun_q <= 1'b1;
      end else if (overrun_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef OVERRUN_COUNT_EN
  logic [7:0] overrun_cnt;

  // Saturating event counter; a new event on the clearing cycle counts as one.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_cnt <= 8'h00;
    end else if (overrun_event) begin
      if (overrun_clear) begin
        overrun_cnt <= 8'h01;
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'h01;
      end
    end else if (overrun_clear) begin
      overrun_cnt <= 8'h00;
    end
  end

  assign overrun_count = overrun_cnt;
`else
  assign overrun_count = 8'h00;
`endif

  assign mcu_start          = (state == ISSUE);
  assign mcu_buffer         = buf_q;
  assign mcu_base_addr      = {slot, {WORD_SHIFT{1'b0}}};
  assign mcu_first_of_frame = mcu_start && (strip_idx == '0) &&
                              (mcu_block_select == '0) && (slot == '0);
  assign mcu_last_of_frame  = mcu_start && (strip_idx == STRIP_MAX) && mcu_last;
  assign busy               = (state != IDLE);
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_mcu_strip_scheduler.sv
// Self-checking bench for mcu_strip_scheduler.
//
// A reference model samples the bench-driven inputs on each rising edge and,
// whenever it decides a strip begins, queues that strip's 40 expected MCU
// starts. A monitor pops one entry per observed mcu_start. A driver process
// owns frontbuffer_select and mcu_done: it acknowledges every start after a
// random delay and applies buffer flips requested by the stimulus process.
`timescale 1ns/1ps

module tb_mcu_strip_scheduler;

  localparam int WIDTH_PIX  = 320;
  localparam int HEIGHT_PIX = 240;
  localparam int NUM_EBR    = 5;
  localparam int EBR_SIZE   = 512;
  localparam int MCUS       = WIDTH_PIX / 8;
  localparam int STRIPS     = HEIGHT_PIX / 8;
  localparam int BLOCK_W    = $clog2(NUM_EBR);
  localparam int ADDR_W     = $clog2(EBR_SIZE);

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               frontbuffer_select = 1'b0;
  logic               mcu_done = 1'b0;
  logic               overrun_clear = 1'b0;
  logic               mcu_start;
  logic               mcu_buffer;
  logic [BLOCK_W-1:0] mcu_block_select;
  logic [ADDR_W-1:0]  mcu_base_addr;
  logic               mcu_first_of_frame;
  logic               mcu_last_of_frame;
  logic               busy;
  logic               overrun;
  logic [7:0]         overrun_count;

  mcu_strip_scheduler #(
    .width_pix  (WIDTH_PIX),
    .height_pix (HEIGHT_PIX),
    .num_ebr    (NUM_EBR),
    .ebr_size   (EBR_SIZE)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .frontbuffer_select (frontbuffer_select),
    .mcu_done           (mcu_done),
    .overrun_clear      (overrun_clear),
    .mcu_start          (mcu_start),
    .mcu_buffer         (mcu_buffer),
    .mcu_block_select   (mcu_block_select),
    .mcu_base_addr      (mcu_base_addr),
    .mcu_first_of_frame (mcu_first_of_frame),
    .mcu_last_of_frame  (mcu_last_of_frame),
    .busy               (busy),
    .overrun            (overrun),
    .overrun_count      (overrun_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic               buf_sel;
    logic [BLOCK_W-1:0] blk;
    logic [ADDR_W-1:0]  base;
    logic               first;
    logic               last;
  } start_t;

  start_t exp_q[$];
  start_t mon_r;
  int     check_cnt = 0;
  int     pass_cnt  = 0;

  // Reference model state.
  logic m_fb_prev = 1'b0;
  logic m_busy    = 1'b0;
  logic m_pending = 1'b0;
  logic m_pend_buf = 1'b0;
  logic m_overrun = 1'b0;
  logic m_tog, m_nb, m_ev;
  int   m_acks = 0;
  int   m_strip = 0;
  int   m_count = 0;
  int   m_events = 0;

  // Requests from stimulus to driver (each side writes only its own counter).
  int tog_req = 0, tog_done = 0;
  int flip_req = 0, flip_done = 0;
  int ack_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Queue every MCU of a newly started strip at the model's frame position.
  function automatic void startStrip(input logic b);
    for (int n = 0; n < MCUS; n++) begin
      start_t r;
      r.buf_sel = b;
      r.blk     = BLOCK_W'(n % NUM_EBR);
      r.base    = ADDR_W'((n / NUM_EBR) * 64);
      r.first   = (m_strip == 0) && (n == 0);
      r.last    = (m_strip == STRIPS - 1) && (n == MCUS - 1);
      exp_q.push_back(r);
    end
    m_busy = 1'b1;
    m_acks = 0;
  endfunction

  // Reference model: completion is applied before a same-cycle buffer flip,
  // so a flip on the final acknowledge starts the next strip cleanly.
  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_fb_prev = 1'b0; m_busy = 1'b0; m_pending = 1'b0; m_pend_buf = 1'b0;
      m_acks = 0; m_strip = 0; m_overrun = 1'b0; m_count = 0;
      exp_q.delete();
    end else begin
      m_tog = (frontbuffer_select != m_fb_prev);
      m_nb = m_fb_prev;
      m_fb_prev = frontbuffer_select;
      m_ev = 1'b0;
      if (mcu_done && m_busy) begin
        m_acks++;
        if (m_acks == MCUS) begin
          m_busy = 1'b0;
          m_acks = 0;
          m_strip = (m_strip + 1) % STRIPS;
          if (m_pending) begin
            m_pending = 1'b0;
            startStrip(m_pend_buf);
          end
        end
      end
      if (m_tog) begin
        if (m_busy) begin
          m_ev = 1'b1;
          m_pending = 1'b1;
          m_pend_buf = m_nb;
        end else begin
          startStrip(m_nb);
        end
      end
      if (m_ev) m_overrun = 1'b1;
      else if (overrun_clear) m_overrun = 1'b0;
`ifdef OVERRUN_COUNT_EN
      if (m_ev) m_count = overrun_clear ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      else if (overrun_clear) m_count = 0;
`endif
      if (m_ev) m_events++;
    end
  end

  // Driver: acknowledges each start 1..4 cycles later and applies flips.
  initial forever begin
    @(posedge clock);
    #1;
    if (reset) begin
      frontbuffer_select = 1'b0;
      mcu_done = 1'b0;
      ack_cnt = 0;
      tog_done = tog_req;
      flip_done = flip_req;
    end else begin
      mcu_done = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          mcu_done = 1'b1;
          if (flip_done != flip_req && m_acks == MCUS - 1) begin
            frontbuffer_select = ~frontbuffer_select;
            flip_done++;
          end
        end
      end
      if (mcu_start) ack_cnt = $urandom_range(1, 4);
      if (tog_done != tog_req) begin
        frontbuffer_select = ~frontbuffer_select;
        tog_done++;
      end
    end
  end

  // Monitor: every start must match the next expected MCU.
  initial forever begin
    @(negedge clock);
    if (!reset && mcu_start) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL start_unexpected: got start buf=%0d blk=%0d base=%0d, expected no start",
                 mcu_buffer, mcu_block_select, mcu_base_addr);
      end else begin
        mon_r = exp_q.pop_front();
        check_cnt++;
        if ({mcu_buffer, mcu_block_select, mcu_base_addr, mcu_first_of_frame,
             mcu_last_of_frame} === mon_r) begin
          pass_cnt++;
        end else begin
          $display("[TB] FAIL start_fields: got buf=%0d blk=%0d base=%0d first=%0d last=%0d, expected buf=%0d blk=%0d base=%0d first=%0d last=%0d",
                   mcu_buffer, mcu_block_select, mcu_base_addr, mcu_first_of_frame,
                   mcu_last_of_frame, mon_r.buf_sel, mon_r.blk, mon_r.base,
                   mon_r.first, mon_r.last);
        end
        checkOutput("busy_with_start", busy, 1);
      end
    end
  end

  // Request one buffer flip and return once it is on the pin.
  task automatic applyStimulus();
    tog_req++;
    @(posedge clock);
    #2;
  endtask

  task automatic waitAcks(input int k);
    int n = 0;
    while (m_acks < k && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("acks_reached", n < 2000, 1);
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (!(exp_q.size() == 0 && !m_busy && !busy && flip_done == flip_req) && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idle_reached", n < bound, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic pulseClear();
    @(negedge clock);
    overrun_clear = 1'b1;
    @(negedge clock);
    overrun_clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int ev0;
    int guard;
    repeat (3) @(negedge clock);
    checkOutput("reset_start", mcu_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_buffer", mcu_buffer, 0);
    checkOutput("reset_block", mcu_block_select, 0);
    checkOutput("reset_base", mcu_base_addr, 0);
    checkOutput("reset_first", mcu_first_of_frame, 0);
    checkOutput("reset_last", mcu_last_of_frame, 0);
    checkOutput("reset_count", overrun_count, 0);
    reset = 1'b0;
    @(negedge clock);

    // First strip: start appears on the edge after the flip is sampled.
    tog_req++;
    @(posedge clock);
    @(negedge clock);
    checkOutput("start_not_early", mcu_start, 0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("first_start_latency", mcu_start, 1);
    checkOutput("first_start_first", mcu_first_of_frame, 1);
    waitIdle(2000);

    // Rest of the frame plus one strip of the next frame.
    for (int s = 1; s <= STRIPS; s++) begin
      applyStimulus();
      waitIdle(2000);
    end
    checkOutput("no_overrun_after_frame", overrun, m_overrun);

    // Flip while around MCU 20: overrun, then the queued strip runs.
    applyStimulus();
    waitAcks(20);
    applyStimulus();
    waitIdle(4000);
    checkOutput("overrun_mid_strip", overrun, m_overrun);
    pulseClear();
    checkOutput("overrun_cleared", overrun, m_overrun);

    // Flip on the same cycle as the final acknowledge is not an overrun.
    applyStimulus();
    flip_req++;
    waitIdle(4000);
    checkOutput("overrun_final_coincide", overrun, m_overrun);

    // Clear and new event on the same cycle: flag stays set.
    applyStimulus();
    waitAcks(10);
    overrun_clear = 1'b1;
    tog_req++;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    overrun_clear = 1'b0;
    checkOutput("clear_vs_event", overrun, m_overrun);
    waitIdle(4000);
    pulseClear();

    // Randomised mix of scenarios.
    for (int it = 0; it < 8; it++) begin
      int k;
      k = $urandom_range(2, 30);
      case ($urandom_range(0, 3))
        0: applyStimulus();
        1: begin applyStimulus(); waitAcks(k); applyStimulus(); end
        2: begin
          applyStimulus(); waitAcks(k); applyStimulus();
          waitAcks(k + 4); applyStimulus();
        end
        default: begin applyStimulus(); flip_req++; end
      endcase
      waitIdle(6000);
      checkOutput("overrun_random", overrun, m_overrun);
      pulseClear();
    end

    // Many overruns to exercise counter saturation.
    ev0 = m_events;
    guard = 0;
    applyStimulus();
    while ((m_events - ev0) < 260 && guard < 20000) begin
      if (m_busy && m_acks >= 1 && m_acks <= MCUS - 5) tog_req++;
      @(posedge clock);
      #2;
      guard++;
    end
    waitIdle(6000);
    checkOutput("stress_events", (m_events - ev0) >= 260, 1);
`ifdef OVERRUN_COUNT_EN
    checkOutput("count_saturated", overrun_count, 255);
`else
    checkOutput("count_tied_zero", overrun_count, 0);
`endif
    checkOutput("count_model", overrun_count, m_count);
    pulseClear();
    checkOutput("count_cleared", overrun_count, m_count);
    checkOutput("overrun_after_stress_clear", overrun, m_overrun);

    // Reset in the middle of a strip aborts it.
    applyStimulus();
    waitAcks(5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_abort_busy", busy, 0);
    checkOutput("reset_abort_start", mcu_start, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_block", mcu_block_select, 0);
    checkOutput("post_reset_overrun", overrun, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
